// File: rtl/rle_encoder.sv
// JPEG baseline run-length encoder: zigzag coefficients in, (run, value) symbols out with DC/ZRL/EOB.
// Latency 1 cycle; input stalls while the output register is held or a ZRL sequence is being emitted.
module rle_encoder #(
  parameter int COEF_WIDTH = 12,
  parameter int BLOCK_SIZE = 64,
  parameter int RUN_WIDTH  = 4,
  parameter int IDX_WIDTH  = $clog2(BLOCK_SIZE)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [COEF_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [RUN_WIDTH+COEF_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  output logic                            err_o
);
  localparam int SYM_W    = RUN_WIDTH + COEF_WIDTH;
  localparam int ZRL_SPAN = 2**RUN_WIDTH;
  localparam logic [RUN_WIDTH-1:0] ZRL_RUN  = '1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic {ST_RUN, ST_ZRL} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0]  r_idx, w_idx_nxt;
  logic [IDX_WIDTH-1:0]  r_zcnt, w_zcnt_nxt;
  logic [COEF_WIDTH-1:0] r_coef, w_coef_nxt;
  logic                  r_last, w_last_nxt;
  logic                  r_m_vld, w_m_vld_nxt;
  logic [SYM_W-1:0]      r_m_dat, w_m_dat_nxt;
  logic                  r_m_last, w_m_last_nxt;
  logic                  r_m_user, w_m_user_nxt;
  logic                  r_err, w_err_nxt;

  logic w_out_free, w_in_hs, w_at_end, w_last_eff, w_len_err, w_is_dc, w_zero, w_zcnt_small;

  assign w_out_free    = !r_m_vld || m_axis_tready;
  assign s_axis_tready = !rst_i && (r_state == ST_RUN) && w_out_free;
  assign w_in_hs       = s_axis_tvalid && s_axis_tready;
  assign w_at_end      = (r_idx == LAST_IDX);
  // A block closes on tlast or on its final index, whichever comes first.
  assign w_last_eff    = s_axis_tlast || w_at_end;
  assign w_len_err     = s_axis_tlast != w_at_end;
  assign w_is_dc       = (r_idx == '0);
  assign w_zero        = (s_axis_tdata == '0);
  assign w_zcnt_small  = (32'(r_zcnt) < ZRL_SPAN);

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_zcnt_nxt   = r_zcnt;
    w_coef_nxt   = r_coef;
    w_last_nxt   = r_last;
    w_m_vld_nxt  = r_m_vld;
    w_m_dat_nxt  = r_m_dat;
    w_m_last_nxt = r_m_last;
    w_m_user_nxt = r_m_user;
    w_err_nxt    = 1'b0;
    if (w_out_free) begin
      w_m_vld_nxt = 1'b0;
    end
    case (r_state)
      ST_RUN: begin
        if (w_in_hs) begin
          w_err_nxt = w_len_err;
          w_idx_nxt = w_last_eff ? '0 : r_idx + 1'b1;
          if (w_is_dc) begin
            w_m_vld_nxt  = 1'b1;
            w_m_dat_nxt  = {{RUN_WIDTH{1'b0}}, s_axis_tdata};
            w_m_last_nxt = w_last_eff;
            w_m_user_nxt = 1'b1;
            w_zcnt_nxt   = '0;
          end else if (w_zero && !w_last_eff) begin
            w_zcnt_nxt = r_zcnt + 1'b1;
          end else if (w_zero) begin
            // Trailing zeros collapse into a single EOB.
            w_m_vld_nxt  = 1'b1;
            w_m_dat_nxt  = '0;
            w_m_last_nxt = 1'b1;
            w_m_user_nxt = 1'b0;
            w_zcnt_nxt   = '0;
          end else if (w_zcnt_small) begin
            w_m_vld_nxt  = 1'b1;
            w_m_dat_nxt  = {RUN_WIDTH'(r_zcnt), s_axis_tdata};
            w_m_last_nxt = w_last_eff;
            w_m_user_nxt = 1'b0;
            w_zcnt_nxt   = '0;
          end else begin
            w_coef_nxt  = s_axis_tdata;
            w_last_nxt  = w_last_eff;
            w_state_nxt = ST_ZRL;
          end
        end
      end
      ST_ZRL: begin
        if (w_out_free) begin
          w_m_vld_nxt  = 1'b1;
          w_m_user_nxt = 1'b0;
          if (w_zcnt_small) begin
            w_m_dat_nxt  = {RUN_WIDTH'(r_zcnt), r_coef};
            w_m_last_nxt = r_last;
            w_zcnt_nxt   = '0;
            w_state_nxt  = ST_RUN;
          end else begin
            w_m_dat_nxt  = {ZRL_RUN, {COEF_WIDTH{1'b0}}};
            w_m_last_nxt = 1'b0;
            w_zcnt_nxt   = r_zcnt - IDX_WIDTH'(ZRL_SPAN);
          end
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_RUN;
      r_idx    <= '0;
      r_zcnt   <= '0;
      r_coef   <= '0;
      r_last   <= 1'b0;
      r_m_vld  <= 1'b0;
      r_m_dat  <= '0;
      r_m_last <= 1'b0;
      r_m_user <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_zcnt   <= w_zcnt_nxt;
      r_coef   <= w_coef_nxt;
      r_last   <= w_last_nxt;
      r_m_vld  <= w_m_vld_nxt;
      r_m_dat  <= w_m_dat_nxt;
      r_m_last <= w_m_last_nxt;
      r_m_user <= w_m_user_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign m_axis_tdata  = r_m_dat;
  assign m_axis_tvalid = r_m_vld;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tuser  = r_m_user;
  assign err_o         = r_err;

endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder: hand-computed symbol streams, stall hold checks, length errors, reset mid-ZRL.
module tb_rle_encoder;
  localparam int CW = 12;
  localparam int RW = 4;
  localparam int SW = CW + RW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [CW-1:0] s_dat = '0;
  logic          s_vld = 1'b0;
  logic          s_rdy;
  logic          s_last = 1'b0;
  logic [SW-1:0] m_dat;
  logic          m_vld;
  logic          m_rdy = 1'b1;
  logic          m_last;
  logic          m_user;
  logic          err;

  always #5 clk_i = ~clk_i;

  rle_encoder #(.COEF_WIDTH(CW), .BLOCK_SIZE(64), .RUN_WIDTH(RW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_axis_tdata(s_dat), .s_axis_tvalid(s_vld), .s_axis_tready(s_rdy), .s_axis_tlast(s_last),
    .m_axis_tdata(m_dat), .m_axis_tvalid(m_vld), .m_axis_tready(m_rdy),
    .m_axis_tlast(m_last), .m_axis_tuser(m_user), .err_o(err)
  );

  typedef struct packed { logic last; logic [CW-1:0] dat; } beat_t;

  beat_t       in_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int lowcnt;
  int errcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sym(input int run, input int val, input bit last, input bit user);
    logic [RW-1:0] r;
    logic [CW-1:0] v;
    r = RW'(run);
    v = CW'(val);
    return {14'd0, last, user, r, v};
  endfunction

  task automatic beat(input int v, input bit last);
    beat_t b;
    b.dat  = CW'(v);
    b.last = last;
    in_q.push_back(b);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) beat(0, 1'b0);
  endtask

  task automatic ex(input int run, input int val, input bit last, input bit user);
    exp_q.push_back(sym(run, val, last, user));
  endtask

  task automatic clear();
    in_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic blk1();
    beat(5, 0); zeros(62); beat(0, 1);
    ex(0, 5, 0, 1); ex(0, 0, 1, 0);
  endtask

  task automatic blk2();
    beat(-3, 0); beat(0, 0); beat(7, 0); zeros(60); beat(0, 1);
    ex(0, -3, 0, 1); ex(1, 7, 0, 0); ex(0, 0, 1, 0);
  endtask

  task automatic blk3();
    beat(1, 0); zeros(20); beat(9, 0); zeros(41); beat(0, 1);
    ex(0, 1, 0, 1); ex(15, 0, 0, 0); ex(4, 9, 0, 0); ex(0, 0, 1, 0);
  endtask

  task automatic blk4();
    beat(0, 0); zeros(62); beat(2, 1);
    ex(0, 0, 0, 1); ex(15, 0, 0, 0); ex(15, 0, 0, 0); ex(15, 0, 0, 0); ex(14, 2, 1, 0);
  endtask

  // Drives in_q, collects accepted symbols, checks held outputs under stall.
  task automatic run(input bit rnd, input bit stop_on_drain);
    int         cyc;
    int         idle;
    bit         prev_stall;
    logic [31:0] prev_out;
    cyc = 0; idle = 0; prev_stall = 0; prev_out = '0;
    lowcnt = 0; errcnt = 0;
    obs_q.delete();
    while (cyc < 3000 && idle < 4) begin
      @(negedge clk_i);
      cyc++;
      m_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_q.size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
        s_vld = 1'b1; s_dat = in_q[0].dat; s_last = in_q[0].last;
      end else begin
        s_vld = 1'b0; s_dat = '0; s_last = 1'b0;
      end
      #1;
      if (prev_stall) chk("stall_hold", {13'd0, m_vld, m_last, m_user, m_dat}, {13'd0, 1'b1, prev_out[17:0]});
      if (err) errcnt++;
      if (!s_rdy) lowcnt++;
      if (m_vld && m_rdy) obs_q.push_back({14'd0, m_last, m_user, m_dat});
      prev_stall = m_vld && !m_rdy;
      prev_out   = {14'd0, m_last, m_user, m_dat};
      if (s_vld && s_rdy) in_q.pop_front();
      if (stop_on_drain && in_q.size() == 0) break;
      if (in_q.size() == 0 && obs_q.size() >= exp_q.size()) idle++;
    end
    if (!stop_on_drain) begin
      @(negedge clk_i);
      s_vld = 1'b0; s_dat = '0; s_last = 1'b0; m_rdy = 1'b1;
    end
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, "_undrained"}, in_q.size(), 0);
    chk({tag, "_nsym"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_sym%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_tvalid", {31'd0, m_vld}, 0);
    chk("rst_tdata", {16'd0, m_dat}, 0);
    chk("rst_tlast_tuser_err", {29'd0, m_last, m_user, err}, 0);
    chk("rst_tready", {31'd0, s_rdy}, 0);
    rst_i = 1'b0;

    clear(); blk1(); run(0, 0); compare("dc_eob");
    chk("dc_eob_err", errcnt, 0);
    chk("dc_eob_stall", lowcnt, 0);

    clear(); blk2(); run(0, 0); compare("run1");
    chk("run1_err", errcnt, 0);

    // One cycle emits the ZRL, the next flushes the held coefficient.
    clear(); blk3(); run(0, 0); compare("zrl1");
    chk("zrl1_stall", lowcnt, 2);
    chk("zrl1_err", errcnt, 0);

    clear(); blk4(); run(0, 0); compare("zrl3_last");
    chk("zrl3_last_stall", lowcnt, 4);
    chk("zrl3_last_err", errcnt, 0);

    clear(); blk3(); blk3(); run(1, 0); compare("random");
    chk("random_err", errcnt, 0);

    // Early tlast, tlast on DC, missing tlast, then a clean block.
    clear();
    beat(4, 0); zeros(9); beat(0, 1);
    ex(0, 4, 0, 1); ex(0, 0, 1, 0);
    beat(6, 1);
    ex(0, 6, 1, 1);
    beat(2, 0); zeros(62); beat(3, 0);
    ex(0, 2, 0, 1); ex(15, 0, 0, 0); ex(15, 0, 0, 0); ex(15, 0, 0, 0); ex(14, 3, 1, 0);
    blk2();
    run(0, 0); compare("lenerr");
    chk("lenerr_pulses", errcnt, 3);

    clear(); blk4(); run(0, 1);
    @(negedge clk_i);
    s_vld = 1'b0; s_dat = '0; s_last = 1'b0; rst_i = 1'b1;
    #1;
    chk("rstzrl_tready", {31'd0, s_rdy}, 0);
    @(negedge clk_i);
    #1;
    chk("rstzrl_tvalid", {31'd0, m_vld}, 0);
    rst_i = 1'b0;
    clear(); blk1(); run(0, 0); compare("after_rst");
    chk("after_rst_err", errcnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
